// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch-address generator
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic RD_BRANCH = 1'b0;
    localparam logic RD_JALR   = 1'b1;

    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/perf_counters.sv
// rtl/perf_counters.sv - free-running cycle counter and retired-instruction counter
module perf_counters #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 retire_i,
    output logic [CNT_WIDTH-1:0] cycle_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    // Both counters wrap silently; they keep counting in BOOT and HALT.
    always_comb begin
        cycle_d   = cycle_q + CNT_WIDTH'(1);
        instret_d = instret_q;
        if (retire_i) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_o   = cycle_q;
    assign instret_o = instret_q;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter / fetch-address generator with redirect, misalign trap and perf counters
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH       = 32,
    parameter int unsigned          CNT_WIDTH        = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR    = '0,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR     = DATA_WIDTH'('h100),
    parameter bit                   HALT_ON_MISALIGN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic                  redirect_kind,
    input  logic [DATA_WIDTH-1:0] br_pc,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  stall,
    input  logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic                  retire,
    output logic                  misalign,
    output logic [DATA_WIDTH-1:0] bad_addr,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  cycle,
    output logic [CNT_WIDTH-1:0]  instret
);

    pc_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  misalign_q, misalign_d;
    logic [DATA_WIDTH-1:0] bad_addr_q, bad_addr_d;
    logic                  halted_q, halted_d;

    logic [DATA_WIDTH-1:0] br_target;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] target;
    logic                  target_misaligned;
    logic                  fetch_fire;

    // JALR clears bit0 first, so only bit1 can make a JALR target misaligned.
    assign br_target         = br_pc + imm;
    assign jalr_sum          = base + imm;
    assign target            = (redirect_kind == RD_JALR) ? {jalr_sum[DATA_WIDTH-1:1], 1'b0}
                                                          : br_target;
    assign target_misaligned = (target[1:0] != 2'b00);
    assign fetch_fire        = fetch_valid_q && fetch_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid && target_misaligned) begin
                    misalign_d = 1'b1;
                    bad_addr_d = target;
                    if (HALT_ON_MISALIGN) begin
                        state_d = HALT;
                    end else begin
                        pc_d = TRAP_VECTOR;
                    end
                end else if (redirect_valid) begin
                    pc_d = target;
                end else if (!stall && fetch_fire) begin
                    pc_d = pc_q + DATA_WIDTH'(INSN_BYTES);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        fetch_valid_d = (state_d == RUN) && !stall;
        halted_d      = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            bad_addr_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            bad_addr_q    <= bad_addr_d;
            halted_q      <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign misalign    = misalign_q;
    assign bad_addr    = bad_addr_q;
    assign halted      = halted_q;

    perf_counters #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_counters (
        .clk       (clk),
        .rst       (rst),
        .retire_i  (retire),
        .cycle_o   (cycle),
        .instret_o (instret)
    );

endmodule
